mem_byte_bridge: RTL

- Converts one CPU load/store of 1, 2, 4 or 8 bytes into a sequence of single-byte transactions on the byte-serial main-memory port.
- Sits between the CPU core's load/store/fetch logic and `main_memory`, and is width-generalised through `MAX_BYTES`.
- Adds features the plain byte port lacks: sign/zero extension, invalid-address abort and read-response timeout.
- Reports one response per accepted request.

---
 rtl/mem_byte_bridge.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_byte_bridge.sv
// -----------------------------------------------------------------------------
// mem_byte_bridge
//
// Splits one CPU load/store of 1, 2, 4 or 8 bytes into a sequence of
// single-byte transactions on the byte-serial main-memory port. Load data is
// reassembled little-endian and sign- or zero-extended to DATA_W. Unmapped
// addresses, read-response timeouts and sizes wider than MAX_BYTES complete
// with an error response. Exactly one response is produced per accepted
// request.
//
// Parameters
//   ADDR_W     CPU address width (zero-extended onto the 64-bit memory addr)
//   MAX_BYTES  widest access in bytes: 1, 2, 4 or 8 (DATA_W = 8*MAX_BYTES)
//   TIMEOUT    cycles after a read accept before the read is declared lost
//
// Ports
//   clk, rstn                 clock (posedge), asynchronous active-low reset
//   req_valid / req_ready     CPU request handshake
//   req_write, req_addr,
//   req_size, req_unsigned,
//   req_wdata                 request fields, latched on acceptance
//   resp_valid                one-cycle completion pulse
//   resp_rdata, resp_err      extended load data (0 for stores/errors), error
//   mode, valid, ready        byte request to memory (mode 1 = write)
//   addr, w_data              byte address and write byte
//   r_data_valid, r_data      returned read byte
//   invalid_addr              memory flags the accepted address as unmapped
// -----------------------------------------------------------------------------
module mem_byte_bridge #(
    parameter int ADDR_W    = 64,
    parameter int MAX_BYTES = 8,
    parameter int TIMEOUT   = 255
) (
    input  logic                   clk,
    input  logic                   rstn,
    // CPU side
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic [1:0]             req_size,
    input  logic                   req_unsigned,
    input  logic [8*MAX_BYTES-1:0] req_wdata,
    output logic                   resp_valid,
    output logic [8*MAX_BYTES-1:0] resp_rdata,
    output logic                   resp_err,
    // Memory side
    output logic                   mode,
    output logic                   valid,
    input  logic                   ready,
    output logic [63:0]            addr,
    output logic [7:0]             w_data,
    input  logic                   r_data_valid,
    input  logic [7:0]             r_data,
    input  logic                   invalid_addr
);

    localparam int DATA_W = 8 * MAX_BYTES;
    localparam int IDX_W  = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
    localparam int CNT_W  = 17;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ISSUE  = 2'd1;
    localparam logic [1:0] S_WAIT_R = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    // Byte count of an access of the given size code.
    function automatic int size_bytes(input logic [1:0] size);
        return 1 << size;
    endfunction

    // Sign- or zero-extend the low 8*N bits of the assembled load word.
    // The value is left-justified, then shifted back down with an arithmetic
    // shift (signed) or a logical shift (unsigned).
    function automatic logic [DATA_W-1:0] extend_load(
        input logic [DATA_W-1:0] raw,
        input logic [1:0]        size,
        input logic              uns
    );
        int                        nbits;
        int                        sh;
        logic signed [DATA_W-1:0]  sx;
        logic        [DATA_W-1:0]  ux;
        nbits = 8 * size_bytes(size);
        if (nbits > DATA_W) nbits = DATA_W;
        sh = DATA_W - nbits;
        ux = raw << sh;
        sx = raw << sh;
        if (uns) return ux >> sh;
        return $unsigned(sx >>> sh);
    endfunction

    logic [1:0]        state;
    logic [IDX_W-1:0]  idx;
    logic [CNT_W-1:0]  tcnt;
    logic              err_p0;
    logic              write_p0;
    logic [1:0]        size_p0;
    logic              unsigned_p0;
    logic [ADDR_W-1:0] addr_p0;
    logic [DATA_W-1:0] wdata_p0;
    logic [DATA_W-1:0] rbuf_p0;

    logic              size_ok;
    logic              last_byte;
    logic              timed_out;
    logic [ADDR_W-1:0] byte_addr;
    logic              issue;
    logic              resp;

    assign size_ok   = size_bytes(req_size) <= MAX_BYTES;
    assign last_byte = int'(idx) == size_bytes(size_p0) - 1;
    // tcnt holds the number of cycles since the read accept; leave WAIT_R
    // so that the error response lands TIMEOUT cycles after the accept.
    assign timed_out = int'(tcnt) + 1 >= TIMEOUT;
    assign byte_addr = addr_p0 + ADDR_W'(idx);

    // ---- stage p0: request capture and byte sequencing ----
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= S_IDLE;
            idx         <= '0;
            tcnt        <= '0;
            err_p0      <= 1'b0;
            write_p0    <= 1'b0;
            size_p0     <= 2'd0;
            unsigned_p0 <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        write_p0    <= req_write;
                        size_p0     <= req_size;
                        unsigned_p0 <= req_unsigned;
                        idx         <= '0;
                        err_p0      <= !size_ok;
                        state       <= size_ok ? S_ISSUE : S_RESP;
                    end
                end
                S_ISSUE: begin
                    if (ready) begin
                        if (invalid_addr) begin
                            err_p0 <= 1'b1;
                            state  <= S_RESP;
                        end else if (write_p0) begin
                            if (last_byte) state <= S_RESP;
                            else           idx   <= idx + 1'b1;
                        end else begin
                            tcnt  <= CNT_W'(1);
                            state <= S_WAIT_R;
                        end
                    end
                end
                S_WAIT_R: begin
                    if (r_data_valid) begin
                        if (last_byte) begin
                            state <= S_RESP;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= S_ISSUE;
                        end
                    end else if (timed_out) begin
                        err_p0 <= 1'b1;
                        state  <= S_RESP;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Data registers carry no reset: every output that shows them is gated
    // by the state, so their contents are never visible out of context.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && req_valid) begin
            addr_p0  <= req_addr;
            wdata_p0 <= req_wdata;
        end
        if (state == S_WAIT_R && r_data_valid) begin
            rbuf_p0[{idx, 3'b000} +: 8] <= r_data;
        end
    end

    // ---- stage p1: memory port and response outputs ----
    assign issue = (state == S_ISSUE);
    assign resp  = (state == S_RESP);

    assign req_ready  = (state == S_IDLE);
    assign valid      = issue;
    assign mode       = issue & write_p0;
    assign addr       = issue ? 64'(byte_addr) : 64'd0;
    assign w_data     = (issue && write_p0) ? wdata_p0[{idx, 3'b000} +: 8] : 8'd0;
    assign resp_valid = resp;
    assign resp_err   = resp & err_p0;
    assign resp_rdata = (resp && !err_p0 && !write_p0)
                        ? extend_load(rbuf_p0, size_p0, unsigned_p0)
                        : '0;

endmodule
